// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the operands, the opcode and the start pulse.
// The unit returns busy together with the architectural HI/LO registers.
interface mul_div_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDop;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDop, start,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDop, start,
    output busy, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit. It owns the HI/LO registers.
// The result is computed when an operation is accepted and is parked in a
// pending register. It is committed to HI/LO after a fixed latency, during
// which busy is held high. mthi/mtlo write HI/LO directly in one cycle.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  md
);

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [2*DATA_W-1:0]     pend, pend_n;
  logic [DATA_W-1:0]       hi, hi_n;
  logic [DATA_W-1:0]       lo, lo_n;

  // Signed 32x32 -> 64 product.
  function automatic logic [2*DATA_W-1:0] mul_s(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ae, be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [2*DATA_W-1:0] mul_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ae, be;
    ae = {{DATA_W{1'b0}}, a};
    be = {{DATA_W{1'b0}}, b};
    return ae * be;
  endfunction

  // Signed divide returning {remainder, quotient}.
  // The division is done one bit wider, so that 0x80000000 / -1 yields +2^31
  // and truncates back to 0x80000000 instead of overflowing.
  // A zero divisor is replaced by 1 only to keep the datapath defined.
  // That result is never committed.
  function automatic logic [2*DATA_W-1:0] div_s(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] ae, be;
    logic [DATA_W-1:0]      q, r;
    ae = {a[DATA_W-1], a};
    be = (b == '0) ? (DATA_W+1)'(1) : {b[DATA_W-1], b};
    q  = DATA_W'(ae / be);
    r  = DATA_W'(ae % be);
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [2*DATA_W-1:0] div_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] bd;
    bd = (b == '0) ? DATA_W'(1) : b;
    return {a % bd, a / bd};
  endfunction

  // Next-state logic: accept work in IDLE; count down and commit in BUSY.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (md.start) begin
          case (md.MDop)
            MD_MULT: begin
              pend_n  = mul_s(md.A, md.B);
              cnt_n   = CNT_W'(MULT_CYCLES);
              state_n = BUSY;
            end
            MD_MULTU: begin
              pend_n  = mul_u(md.A, md.B);
              cnt_n   = CNT_W'(MULT_CYCLES);
              state_n = BUSY;
            end
            MD_DIV: begin
              if (md.B != '0) begin
                pend_n  = div_s(md.A, md.B);
                cnt_n   = CNT_W'(DIV_CYCLES);
                state_n = BUSY;
              end
            end
            MD_DIVU: begin
              if (md.B != '0) begin
                pend_n  = div_u(md.A, md.B);
                cnt_n   = CNT_W'(DIV_CYCLES);
                state_n = BUSY;
              end
            end
            MD_MTHI: hi_n = md.A;
            MD_MTLO: lo_n = md.A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Starts are dropped here; the pipeline stalls them in D.
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_n    = pend[2*DATA_W-1:DATA_W];
          lo_n    = pend[DATA_W-1:0];
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  assign md.busy = (state == BUSY);
  assign md.HI   = hi;
  assign md.LO   = lo;

endmodule
